// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over windows of WIN_LEN valid bits.
// Optional sticky overrun flag (ovf) is built when SC_DEC_OVF_EN is defined.
module sc_bitstream_decoder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned WIN_LEN = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
`ifdef SC_DEC_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StCount = 1'b1;

  localparam logic [WIDTH-1:0] LastIdx = WIDTH'(WIN_LEN - 1);

  // ones is bounded by WIN_LEN, so a window that fits the counter can never wrap.
  if (WIN_LEN < 1 || longint'(WIN_LEN) > ((longint'(1) << WIDTH) - longint'(1)))
  begin : g_bad_win_len
    $error("sc_bitstream_decoder: WIN_LEN must be in 1..2^WIDTH-1");
  end

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [WIDTH-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic             win_close;

  assign win_close = (state_q == StCount) && bit_valid && (win_cnt_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    ones_d    = ones_q;
    result_d  = result_q;
    rv_d      = rv_q;
    if (rv_q && result_ready) rv_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCount;
          win_cnt_d = '0;
          ones_d    = '0;
        end
      end
      StCount: begin
        if (bit_valid) begin
          if (win_close) begin
            // A closing window always wins over a pending transfer.
            result_d  = ones_q + WIDTH'(bit_in);
            rv_d      = 1'b1;
            win_cnt_d = '0;
            ones_d    = '0;
            state_d   = cont ? StCount : StIdle;
          end else begin
            win_cnt_d = win_cnt_q + WIDTH'(1);
            ones_d    = ones_q + WIDTH'(bit_in);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      ones_q    <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
    end
  end

`ifdef SC_DEC_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StIdle && start) ovf_d = 1'b0;
    if (win_close && rv_q && !result_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = (state_q == StCount);

endmodule
